// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential Booth multiplier.
// Build option: define SEQ_MULT_RADIX4_EN for radix-4 recoding (two multiplier
// bits per step); leave it undefined for radix-2 (one bit per step).
package seq_mult_pkg;

`ifdef SEQ_MULT_RADIX4_EN
    localparam int EXT_BITS  = 2;  // operand extension beyond WIDTH
    localparam int SHIFT     = 2;  // multiplier bits retired per step
    localparam int INSPECT_W = 3;  // {q1, q0, q(-1)}
`else
    localparam int EXT_BITS  = 1;
    localparam int SHIFT     = 1;
    localparam int INSPECT_W = 2;  // {q0, q(-1)}
`endif

    // Controller states, kept as plain constants for compatibility with the
    // existing ALU sequencer, which compares raw encodings.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Selected multiple of M that is added to the accumulator in one step.
    typedef enum logic [2:0] {
        DIG_ZERO = 3'd0,
        DIG_POS1 = 3'd1,
        DIG_NEG1 = 3'd2,
        DIG_POS2 = 3'd3,
        DIG_NEG2 = 3'd4
    } booth_digit_t;

    // Iterations needed to consume the whole extended multiplier:
    // WIDTH+1 for radix-2, (WIDTH+2)/2 for radix-4.
    function automatic int mult_cycles(input int width);
        return (width + EXT_BITS) / SHIFT;
    endfunction

endpackage

// File: rtl/seq_mult_booth_recoder.sv
// Combinational Booth recoder: maps the inspected multiplier bits to the
// multiple of M applied this step. Radix follows SEQ_MULT_RADIX4_EN.
module booth_recoder
    import seq_mult_pkg::*;
(
    input  logic [INSPECT_W-1:0] bits,
    output booth_digit_t         digit
);

    // Decode the multiplier window into a signed digit.
    always_comb begin
        // NOTE: default first so every path assigns digit and no latch is inferred.
        digit = DIG_ZERO;
`ifdef SEQ_MULT_RADIX4_EN
        case (bits)
            3'b001, 3'b010: digit = DIG_POS1;
            3'b011:         digit = DIG_POS2;
            3'b100:         digit = DIG_NEG2;
            3'b101, 3'b110: digit = DIG_NEG1;
            default:        digit = DIG_ZERO;
        endcase
`else
        case (bits)
            2'b01:   digit = DIG_POS1;
            2'b10:   digit = DIG_NEG1;
            default: digit = DIG_ZERO;
        endcase
`endif
    end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential Booth multiplier with start/done handshake, one Booth step per
// clock. signed_mode selects two's-complement or unsigned operands.
// Build option: SEQ_MULT_RADIX4_EN selects radix-4 steps (shorter latency).
module seq_booth_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int EW    = WIDTH + EXT_BITS;   // extended operand width
    localparam int AW    = EW + 1;             // accumulator keeps headroom for +/-2M
    localparam int N_CYC = mult_cycles(WIDTH);
    localparam int CW    = $clog2(N_CYC + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   acc;
    logic [EW-1:0]   m_reg;
    logic [EW-1:0]   q_reg;
    logic            qm1;

    logic [EW-1:0]   a_ext;
    logic [EW-1:0]   b_ext;
    logic [AW-1:0]   m_ext;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   sum;
    logic [AW+EW:0]  step_in;
    logic [AW+EW:0]  step_out;
    logic [AW-1:0]   next_acc;
    logic [EW-1:0]   next_q;
    logic            next_qm1;
    booth_digit_t    digit;

    // Sign- or zero-extend the operands as they are captured.
    assign a_ext = signed_mode ? {{EXT_BITS{a[WIDTH-1]}}, a} : {{EXT_BITS{1'b0}}, a};
    assign b_ext = signed_mode ? {{EXT_BITS{b[WIDTH-1]}}, b} : {{EXT_BITS{1'b0}}, b};
    assign m_ext = {m_reg[EW-1], m_reg};

    booth_recoder u_recoder (
        .bits  ({q_reg[INSPECT_W-2:0], qm1}),
        .digit (digit)
    );

    // One Booth step: add the selected multiple of M, then arithmetic shift
    // the whole {acc, q, q(-1)} register right.
    always_comb begin
        addend = '0;
        case (digit)
            DIG_POS1: addend = m_ext;
            DIG_NEG1: addend = -m_ext;
            DIG_POS2: addend = {m_ext[AW-2:0], 1'b0};
            DIG_NEG2: addend = -{m_ext[AW-2:0], 1'b0};
            default:  addend = '0;
        endcase
        sum      = acc + addend;
        step_in  = {sum, q_reg, qm1};
        step_out = $signed(step_in) >>> SHIFT;
        next_acc = step_out[AW+EW -: AW];
        next_q   = step_out[EW:1];
        next_qm1 = step_out[0];
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // Controller, iteration counter, datapath registers and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every datapath register is reset too, so an aborted
            // operation leaves no residue in acc/q/counter.
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            m_reg  <= '0;
            q_reg  <= '0;
            qm1    <= 1'b0;
            result <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the step logic.
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_RUN;
                        m_reg <= a_ext;
                        q_reg <= b_ext;
                        acc   <= '0;
                        qm1   <= 1'b0;
                        cnt   <= CW'(N_CYC);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc   <= next_acc;
                    q_reg <= next_q;
                    qm1   <= next_qm1;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state  <= ST_DONE;
                        result <= {next_acc[2*WIDTH-EW-1:0], next_q};
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Scoreboard testbench for seq_booth_multiplier (WIDTH=8). Works in either
// build of SEQ_MULT_RADIX4_EN; expected latency follows the compiled radix.
module tb_seq_booth_multiplier;
    import seq_mult_pkg::*;

    localparam int WIDTH = 8;
    localparam int N     = (WIDTH + EXT_BITS) / SHIFT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] result;

    typedef struct {
        logic [15:0] res;
        int          due;
        string       tag;
    } exp_t;

    typedef struct packed {
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
    } vec_t;

    exp_t scoreboard[$];
    exp_t mon_e;
    int   cycle    = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    vec_t vecs[10] = '{
        '{1'b0, 8'h00, 8'h00, 16'h0000},
        '{1'b0, 8'h01, 8'h01, 16'h0001},
        '{1'b0, 8'h02, 8'h03, 16'h0006},
        '{1'b0, 8'h0F, 8'h0F, 16'h00E1},
        '{1'b0, 8'hFF, 8'hFF, 16'hFE01},
        '{1'b0, 8'h80, 8'h7F, 16'h3F80},
        '{1'b1, 8'hFF, 8'hFF, 16'h0001},
        '{1'b1, 8'h80, 8'h80, 16'h4000},
        '{1'b1, 8'h80, 8'h7F, 16'hC080},
        '{1'b1, 8'h05, 8'hFD, 16'hFFF1}
    };

    seq_booth_multiplier #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to time done pulses.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (scoreboard.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = scoreboard.pop_front();
                check({mon_e.tag, "_result"}, 32'(result), 32'(mon_e.res));
                check({mon_e.tag, "_latency"}, 32'(cycle), 32'(mon_e.due));
                check({mon_e.tag, "_busy_low"}, 32'(busy), 32'd0);
            end
        end
    end

    // Called just after a negedge: presents operands, start is sampled on the next edge (E0).
    task automatic issue(input string tag, input logic sm, input logic [7:0] aa,
                         input logic [7:0] bb, input logic [15:0] expv, input bit track);
        start       = 1'b1;
        signed_mode = sm;
        a           = aa;
        b           = bb;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (track) scoreboard.push_back('{expv, cycle + N, tag});
    endtask

    // Wait (bounded) until every expectation has been consumed.
    task automatic drain();
        int k = 0;
        while (scoreboard.size() != 0 && k < 4 * N) begin
            @(negedge clk);
            k++;
        end
        if (scoreboard.size() != 0) begin
            check("drain_timeout", 32'(scoreboard.size()), 32'd0);
            scoreboard.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ua, ub, sa, sb_op, model;
        int k;
        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed unsigned and signed vectors.
        for (int i = 0; i < 10; i++) begin
            issue($sformatf("vec%0d", i), vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].res, 1'b1);
            drain();
        end
        repeat (3) @(negedge clk);
        check("result_hold", 32'(result), 32'h0000FFF1);

        // start with new operands while running must be ignored.
        issue("midrun", 1'b0, 8'd12, 8'd10, 16'd120, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1; signed_mode = 1'b1; a = 8'hFF; b = 8'h80;
        check("midrun_busy_a", 32'(busy), 32'd1);
        @(negedge clk);
        check("midrun_busy_b", 32'(busy), 32'd1);
        start = 1'b0;
        drain();

        // Back-to-back: start held in the DONE cycle.
        issue("b2b_first", 1'b0, 8'd7, 8'd9, 16'd63, 1'b1);
        k = 0;
        while (!done && k < 4 * N) begin
            @(negedge clk);
            k++;
        end
        check("b2b_saw_done", 32'(done), 32'd1);
        issue("b2b_second", 1'b1, 8'hF6, 8'h03, 16'hFFE2, 1'b1);
        drain();

        // Reset during iteration 3 aborts without a done pulse.
        issue("aborted", 1'b0, 8'd100, 8'd100, 16'h0000, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 4) @(negedge clk);
        check("abort_idle_busy", 32'(busy), 32'd0);
        issue("after_reset", 1'b0, 8'd100, 8'd100, 16'h2710, 1'b1);
        drain();

        // A few random operations against a simple multiply model.
        for (int i = 0; i < 16; i++) begin
            logic       sm;
            logic [7:0] ra, rb;
            sm    = 1'($urandom_range(1, 0));
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            ua    = {8'h00, ra};
            ub    = {8'h00, rb};
            sa    = {{8{ra[7]}}, ra};
            sb_op = {{8{rb[7]}}, rb};
            model = sm ? 16'(sa * sb_op) : 16'(ua * ub);
            issue($sformatf("rand%0d", i), sm, ra, rb, model, 1'b1);
            drain();
        end

        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
